// File: rtl/div_unit_pkg.sv
// Shared constants for the divide unit: default datapath width and op encodings.
package div_unit_pkg;

    localparam int unsigned DIV_DATA_WIDTH = 32;

    // div_control[2] selects signed operation; [1:0] == 00 is not a divide
    localparam logic [2:0] DIV_CTRL_DIV  = 3'b110;
    localparam logic [2:0] DIV_CTRL_DIVU = 3'b010;
    localparam logic [2:0] DIV_CTRL_REM  = 3'b101;
    localparam logic [2:0] DIV_CTRL_REMU = 3'b001;

endpackage

// File: rtl/div_unit.sv
// Iterative restoring radix-2 divider producing signed and unsigned quotient/remainder.
// Divide-by-zero and signed overflow resolve in a single cycle.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DIV_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  div_req_valid,
    output logic                  div_req_ready,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    input  logic [2:0]            div_control,
    input  logic                  div_flush,
    output logic                  div_type_ok,
    input  logic                  div_rsp_ready,
    output logic [DATA_WIDTH-1:0] signed_div_res,
    output logic [DATA_WIDTH-1:0] unsigned_div_res,
    output logic [DATA_WIDTH-1:0] signed_rem_res,
    output logic [DATA_WIDTH-1:0] unsigned_rem_res
);

    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] rem_q;
    logic [DATA_WIDTH-1:0] quo_q;
    logic [DATA_WIDTH-1:0] dvs_q;
    logic                  neg_quo;
    logic                  neg_rem;

    logic                  accept;
    logic                  op_signed;
    logic                  div_zero;
    logic                  overflow;
    logic [DATA_WIDTH-1:0] dividend_mag;
    logic [DATA_WIDTH-1:0] divisor_mag;
    logic [DATA_WIDTH:0]   shifted;
    logic [DATA_WIDTH:0]   trial;
    logic [DATA_WIDTH-1:0] next_rem;
    logic [DATA_WIDTH-1:0] next_quo;
    logic [DATA_WIDTH-1:0] fin_quo;
    logic [DATA_WIDTH-1:0] fin_rem;

    assign div_req_ready = (state == IDLE);

    // Request decode and operand magnitudes
    assign accept       = div_req_valid && (state == IDLE) && (div_control[1:0] != 2'b00);
    assign op_signed    = div_control[2];
    assign div_zero     = (divisor == '0);
    assign overflow     = op_signed && (dividend == MIN_NEG) && (divisor == '1);
    assign dividend_mag = (op_signed && dividend[DATA_WIDTH-1]) ? (~dividend + DATA_WIDTH'(1)) : dividend;
    assign divisor_mag  = (op_signed && divisor[DATA_WIDTH-1])  ? (~divisor + DATA_WIDTH'(1))  : divisor;

    // One restoring step: the borrow bit of the trial subtraction decides the quotient bit
    assign shifted  = {rem_q, quo_q[DATA_WIDTH-1]};
    assign trial    = shifted - {1'b0, dvs_q};
    assign next_rem = trial[DATA_WIDTH] ? shifted[DATA_WIDTH-1:0] : trial[DATA_WIDTH-1:0];
    assign next_quo = {quo_q[DATA_WIDTH-2:0], ~trial[DATA_WIDTH]};
    assign fin_quo  = neg_quo ? (~next_quo + DATA_WIDTH'(1)) : next_quo;
    assign fin_rem  = neg_rem ? (~next_rem + DATA_WIDTH'(1)) : next_rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            rem_q            <= '0;
            quo_q            <= '0;
            dvs_q            <= '0;
            neg_quo          <= 1'b0;
            neg_rem          <= 1'b0;
            div_type_ok      <= 1'b0;
            signed_div_res   <= '0;
            unsigned_div_res <= '0;
            signed_rem_res   <= '0;
            unsigned_rem_res <= '0;
        end else if (div_flush) begin
            state       <= IDLE;
            cnt         <= '0;
            div_type_ok <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (div_zero) begin
                            state            <= DONE;
                            div_type_ok      <= 1'b1;
                            signed_div_res   <= '1;
                            unsigned_div_res <= '1;
                            signed_rem_res   <= dividend;
                            unsigned_rem_res <= dividend;
                        end else if (overflow) begin
                            state            <= DONE;
                            div_type_ok      <= 1'b1;
                            signed_div_res   <= MIN_NEG;
                            unsigned_div_res <= MIN_NEG;
                            signed_rem_res   <= '0;
                            unsigned_rem_res <= '0;
                        end else begin
                            state   <= CALC;
                            cnt     <= '0;
                            rem_q   <= '0;
                            quo_q   <= dividend_mag;
                            dvs_q   <= divisor_mag;
                            neg_quo <= op_signed && (dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1]);
                            neg_rem <= op_signed && dividend[DATA_WIDTH-1];
                        end
                    end
                end
                CALC: begin
                    rem_q <= next_rem;
                    quo_q <= next_quo;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST_ITER) begin
                        state            <= DONE;
                        cnt              <= '0;
                        div_type_ok      <= 1'b1;
                        unsigned_div_res <= next_quo;
                        unsigned_rem_res <= next_rem;
                        signed_div_res   <= fin_quo;
                        signed_rem_res   <= fin_rem;
                    end
                end
                DONE: begin
                    if (div_rsp_ready) begin
                        state       <= IDLE;
                        div_type_ok <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    div_type_ok <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, sign handling, special cases,
// backpressure, flush and asynchronous reset.
module tb_div_unit;

    logic        clk;
    logic        rst_n;
    logic        div_req_valid;
    logic        div_req_ready;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [2:0]  div_control;
    logic        div_flush;
    logic        div_type_ok;
    logic        div_rsp_ready;
    logic [31:0] signed_div_res;
    logic [31:0] unsigned_div_res;
    logic [31:0] signed_rem_res;
    logic [31:0] unsigned_rem_res;

    int checks;
    int failures;
    int seen_ok;

    div_unit #(.DATA_WIDTH(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .div_req_valid    (div_req_valid),
        .div_req_ready    (div_req_ready),
        .dividend         (dividend),
        .divisor          (divisor),
        .div_control      (div_control),
        .div_flush        (div_flush),
        .div_type_ok      (div_type_ok),
        .div_rsp_ready    (div_rsp_ready),
        .signed_div_res   (signed_div_res),
        .unsigned_div_res (unsigned_div_res),
        .signed_rem_res   (signed_rem_res),
        .unsigned_rem_res (unsigned_rem_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Present a request for one accept edge; returns 1 time unit after that edge
    task automatic issue(input logic [2:0] ctrl, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        div_req_valid = 1'b1;
        div_control   = ctrl;
        dividend      = a;
        divisor       = b;
        @(posedge clk);
        #1;
        div_req_valid = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic respond(input string tag);
        @(negedge clk);
        div_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        div_rsp_ready = 1'b0;
        check({tag, "_ok_low"}, 32'(div_type_ok), 32'd0);
        check({tag, "_ready_high"}, 32'(div_req_ready), 32'd1);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        div_req_valid = 1'b0;
        dividend      = '0;
        divisor       = '0;
        div_control   = 3'b000;
        div_flush     = 1'b0;
        div_rsp_ready = 1'b0;

        #12;
        check("rst_ready", 32'(div_req_ready), 32'd1);
        check("rst_ok", 32'(div_type_ok), 32'd0);
        check("rst_udiv", unsigned_div_res, 32'd0);
        check("rst_srem", signed_rem_res, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // DIVU 100/7: 32-cycle latency
        issue(3'b010, 32'd100, 32'd7);
        check("divu_busy", 32'(div_req_ready), 32'd0);
        step(31);
        check("divu_ok_at31", 32'(div_type_ok), 32'd0);
        step(1);
        check("divu_ok_at32", 32'(div_type_ok), 32'd1);
        check("divu_uq", unsigned_div_res, 32'd14);
        check("divu_ur", unsigned_rem_res, 32'd2);
        check("divu_sq", signed_div_res, 32'd14);
        check("divu_sr", signed_rem_res, 32'd2);
        respond("divu");

        // DIV -7/2: quotient truncates toward zero, remainder follows dividend
        issue(3'b110, 32'hFFFF_FFF9, 32'd2);
        step(32);
        check("div_neg_ok", 32'(div_type_ok), 32'd1);
        check("div_neg_sq", signed_div_res, 32'hFFFF_FFFD);
        check("div_neg_sr", signed_rem_res, 32'hFFFF_FFFF);
        check("div_neg_uq_mag", unsigned_div_res, 32'd3);
        check("div_neg_ur_mag", unsigned_rem_res, 32'd1);
        respond("div_neg");

        // REM 100 / -7: quotient negative, remainder positive
        issue(3'b101, 32'd100, 32'hFFFF_FFF9);
        step(32);
        check("rem_sq", signed_div_res, 32'hFFFF_FFF2);
        check("rem_sr", signed_rem_res, 32'd2);
        respond("rem");

        // DIVU 5/0: single-cycle response
        issue(3'b010, 32'd5, 32'd0);
        check("dz_ok", 32'(div_type_ok), 32'd1);
        check("dz_uq", unsigned_div_res, 32'hFFFF_FFFF);
        check("dz_ur", unsigned_rem_res, 32'd5);
        check("dz_sq", signed_div_res, 32'hFFFF_FFFF);
        check("dz_sr", signed_rem_res, 32'd5);
        respond("dz");

        // DIV MIN/-1 overflow, then hold DONE under backpressure
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
        check("ovf_ok", 32'(div_type_ok), 32'd1);
        check("ovf_sq", signed_div_res, 32'h8000_0000);
        check("ovf_sr", signed_rem_res, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("bp_ok", 32'(div_type_ok), 32'd1);
            check("bp_ready", 32'(div_req_ready), 32'd0);
            check("bp_sq", signed_div_res, 32'h8000_0000);
            check("bp_sr", signed_rem_res, 32'd0);
        end

        // Request waiting during the response handshake is taken one edge later
        @(negedge clk);
        div_rsp_ready = 1'b1;
        div_req_valid = 1'b1;
        div_control   = 3'b010;
        dividend      = 32'd20;
        divisor       = 32'd6;
        @(posedge clk);
        #1;
        div_rsp_ready = 1'b0;
        check("hs_ok_low", 32'(div_type_ok), 32'd0);
        check("hs_idle", 32'(div_req_ready), 32'd1);
        step(1);
        div_req_valid = 1'b0;
        check("hs_next_accepted", 32'(div_req_ready), 32'd0);
        step(31);
        check("hs_next_ok_at31", 32'(div_type_ok), 32'd0);
        step(1);
        check("hs_next_ok", 32'(div_type_ok), 32'd1);
        check("hs_next_uq", unsigned_div_res, 32'd3);
        check("hs_next_ur", unsigned_rem_res, 32'd2);
        respond("hs_next");

        // div_control[1:0] == 00 is ignored
        @(negedge clk);
        div_req_valid = 1'b1;
        div_control   = 3'b100;
        step(2);
        check("ignored_ready", 32'(div_req_ready), 32'd1);
        check("ignored_ok", 32'(div_type_ok), 32'd0);
        div_req_valid = 1'b0;

        // Flush at iteration 10, no response afterwards
        issue(3'b010, 32'd1000, 32'd3);
        step(10);
        @(negedge clk);
        div_flush = 1'b1;
        @(posedge clk);
        #1;
        div_flush = 1'b0;
        check("flush_idle", 32'(div_req_ready), 32'd1);
        seen_ok = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (div_type_ok) seen_ok++;
        end
        check("flush_no_rsp", 32'(seen_ok), 32'd0);
        issue(3'b010, 32'd9, 32'd3);
        step(32);
        check("post_flush_ok", 32'(div_type_ok), 32'd1);
        check("post_flush_uq", unsigned_div_res, 32'd3);
        check("post_flush_ur", unsigned_rem_res, 32'd0);
        respond("post_flush");

        // Asynchronous reset mid-calculation takes effect between edges
        issue(3'b010, 32'd1000, 32'd3);
        step(10);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ready", 32'(div_req_ready), 32'd1);
        check("arst_ok", 32'(div_type_ok), 32'd0);
        check("arst_uq_clear", unsigned_div_res, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_ok = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (div_type_ok) seen_ok++;
        end
        check("arst_no_rsp", 32'(seen_ok), 32'd0);
        issue(3'b010, 32'd9, 32'd3);
        step(32);
        check("post_rst_ok", 32'(div_type_ok), 32'd1);
        check("post_rst_uq", unsigned_div_res, 32'd3);
        check("post_rst_ur", unsigned_rem_res, 32'd0);
        respond("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have exactly one clock and one reset: clk input 1 (rising edge), rst_n input 1 (asynchronous, active-low).
REQ-002 Ports:
- div_req_valid  in  1  EX presents a divide request
- div_req_ready  out  1  unit can accept a request
- dividend  in  DATA_WIDTH  rs1 operand
- divisor  in  DATA_WIDTH  rs2 operand
- div_control  in  3  op code: 110 DIV, 010 DIVU, 101 REM, 001 REMU; div_control[2] = signed
- div_flush  in  1  abandon the current operation
- div_type_ok  out  1  response valid
- div_rsp_ready  in  1  EX accepts the response; tied to allow_in_wb
- signed_div_res  out  DATA_WIDTH  signed quotient
- unsigned_div_res  out  DATA_WIDTH  unsigned quotient
- signed_rem_res  out  DATA_WIDTH  signed remainder
- unsigned_rem_res  out  DATA_WIDTH  unsigned remainder
REQ-003 Parameter: DATA_WIDTH, default 32, datapath width; the iteration count equals DATA_WIDTH.

Function
REQ-004 States SHALL be IDLE, CALC and DONE.
REQ-005 div_req_ready SHALL be 1 only in IDLE; it is combinational from state.
REQ-006 A request SHALL be accepted on an edge with div_req_valid=1, div_req_ready=1 and div_control[1:0]!=00. On acceptance the unit latches the operands and signedness.
REQ-007 Divisor zero SHALL go IDLE->DONE in one edge with these results:
- quotient = all ones
- remainder = dividend
- applies to the signed and unsigned outputs alike
REQ-008 Signed op with dividend=0x80000000 and divisor=0xFFFFFFFF SHALL go IDLE->DONE in one edge with quotient 0x80000000 and remainder 0.
REQ-009 Otherwise the unit SHALL go IDLE->CALC:
- operands are converted to magnitudes if signed
- restoring radix-2 division, one quotient bit per edge, iteration counter 0..DATA_WIDTH-1
- the final iteration edge transitions to DONE
- div_type_ok rises exactly DATA_WIDTH cycles after the accept edge
REQ-010 Sign correction SHALL be applied on the final edge:
- quotient negated if the operand signs differ
- remainder takes the dividend's sign
REQ-011 For unsigned ops, signed_* outputs SHALL equal unsigned_* outputs; for signed ops, unsigned_* outputs SHALL equal the uncorrected magnitudes.
REQ-012 div_type_ok SHALL be 1 exactly in DONE; results are registered and stable throughout DONE.
REQ-013 DONE->IDLE SHALL occur on an edge with div_rsp_ready=1. With div_rsp_ready=0 the unit holds DONE and its outputs indefinitely.
REQ-014 No new request SHALL be accepted on the same edge as the response handshake; the earliest next accept is the following edge.
REQ-015 div_flush=1 SHALL force IDLE on the next edge from any state, with no response produced. Flush overrides a simultaneous accept or response handshake.
REQ-016 Requests with div_control[1:0]=00 SHALL be ignored, and the state stays IDLE.

Reset
REQ-017 While rst_n=0 the block SHALL hold:
- state = IDLE, counter = 0
- all result registers = 0
- div_type_ok = 0, div_req_ready = 1
REQ-018 Reset asserted mid-CALC or in DONE SHALL discard the operation immediately, without waiting for a clock edge.

Structure
REQ-019 DATA_WIDTH and the div_control encodings SHALL live in the shared include.v; state encodings stay local.
REQ-020 No sub-module SHALL be used: the iteration datapath (remainder/quotient shift registers and subtractor) stays in div_unit.

Verification
REQ-021 DIVU 100/7 -> unsigned_div_res=14, unsigned_rem_res=2; div_type_ok high 32 cycles after accept.
REQ-022 DIV/REM 0xFFFFFFF9 (-7) / 2 -> signed_div_res=0xFFFFFFFD (-3), signed_rem_res=0xFFFFFFFF (-1).
REQ-023 DIVU 5/0 -> quotient 0xFFFFFFFF, remainder 5; div_type_ok high 1 cycle after accept.
REQ-024 DIV 0x80000000/0xFFFFFFFF -> signed_div_res=0x80000000, signed_rem_res=0; response in 1 cycle.
REQ-025 Backpressure: div_rsp_ready=0 for 5 cycles in DONE -> outputs stable and div_req_ready=0 throughout; after the handshake the next request is accepted one edge later.
REQ-026 Flush or reset at iteration 10 -> IDLE (immediately for reset, next edge for flush); no div_type_ok pulse; a subsequent DIVU 9/3 returns 3 rem 0.
